// File: rtl/wb_trng_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_trng_fetch_pkg
// Description : Shared types and Wishbone classic-cycle constants for the
//               TRNG byte fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_trng_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } fetch_state_t;

    localparam logic [2:0] c_cti_classic = 3'b000;
    localparam logic [1:0] c_bte_linear  = 2'b00;

endpackage : wb_trng_fetch_pkg
`default_nettype wire

// File: rtl/trng_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trng_word_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_full) || w_do_pop);

    // Head is forced to zero while empty so stale storage never leaks out.
    assign o_rdata = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : trng_word_fifo
`default_nettype wire

// File: rtl/wb_trng_fetch.sv
`default_nettype none
// ============================================================================
// Module      : wb_trng_fetch
// Description : Wishbone master that reads TRNG bytes, packs them into 32-bit
//               words and queues the words in a FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trng_fetch
    import wb_trng_fetch_pkg::*;
#(
    parameter logic [31:0] TRNG_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    output logic [31:0]            wb_adr_o,
    output logic [7:0]             wb_dat_o,
    output logic                   wb_we_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic [2:0]             wb_cti_o,
    output logic [1:0]             wb_bte_o,
    input  logic [7:0]             wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i,
    input  logic                   enable,
    output logic [31:0]            rnd_data,
    output logic                   rnd_valid,
    input  logic                   rnd_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   fault,
    input  logic                   fault_clr
);
    localparam int              c_lw       = $clog2(DEPTH) + 1;
    localparam logic [c_lw-1:0] c_depth    = c_lw'(DEPTH);
    localparam logic [9:0]      c_tmo_last = 10'(TIMEOUT - 1);

    fetch_state_t r_state;
    logic         r_cyc;
    logic [1:0]   r_byte_cnt;
    logic [23:0]  r_word;
    logic [9:0]   r_tmo;
    logic         r_fault;
    logic         w_launch;
    logic         w_push;
    logic         w_tmo_expire;

    assign w_launch     = enable && !r_fault && ((r_byte_cnt != 2'd0) || (level < c_depth));
    assign w_tmo_expire = (r_tmo == c_tmo_last);
    assign w_push       = (r_state == ST_REQ) && !wb_err_i && wb_ack_i && (r_byte_cnt == 2'd3);

    assign wb_adr_o = TRNG_ADDR;
    assign wb_dat_o = 8'h00;
    assign wb_we_o  = 1'b0;
    assign wb_cti_o = c_cti_classic;
    assign wb_bte_o = c_bte_linear;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign fault    = r_fault;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state    <= ST_IDLE;
            r_cyc      <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_word     <= '0;
            r_tmo      <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (fault_clr) begin
                r_fault <= 1'b0;
            end
            case (r_state)
                // GAP re-evaluates the launch condition itself, so a stream
                // costs exactly REQ, ack-REQ, GAP per byte.
                ST_IDLE, ST_GAP: begin
                    if (w_launch) begin
                        r_state <= ST_REQ;
                        r_cyc   <= 1'b1;
                        r_tmo   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cyc   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (wb_err_i || (!wb_ack_i && !wb_rty_i && w_tmo_expire)) begin
                        r_fault    <= 1'b1;
                        r_byte_cnt <= 2'd0;
                        r_state    <= ST_GAP;
                        r_cyc      <= 1'b0;
                    end else if (wb_ack_i) begin
                        case (r_byte_cnt)
                            2'd0:    r_word[7:0]   <= wb_dat_i;
                            2'd1:    r_word[15:8]  <= wb_dat_i;
                            2'd2:    r_word[23:16] <= wb_dat_i;
                            default: r_word        <= r_word;
                        endcase
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_state    <= ST_GAP;
                        r_cyc      <= 1'b0;
                    end else if (wb_rty_i) begin
                        r_state <= ST_GAP;
                        r_cyc   <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + 10'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    trng_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (wb_clk),
        .rst     (wb_rst),
        .i_push  (w_push),
        .i_wdata ({wb_dat_i, r_word}),
        .i_pop   (rnd_ready),
        .o_rdata (rnd_data),
        .o_valid (rnd_valid),
        .o_count (level)
    );

endmodule : wb_trng_fetch
`default_nettype wire

// File: tb/tb_wb_trng_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_trng_fetch
// Description : Directed self-checking bench for wb_trng_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trng_fetch;
    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [31:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [7:0]  wb_dat_i = 8'h00;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] rnd_data;
    logic        rnd_valid;
    logic        rnd_ready = 1'b0;
    logic [2:0]  level;
    logic        fault;
    logic        fault_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Responder model state
    int         cycle       = 0;
    int         stb_age     = 0;
    int         stb_issued  = 0;
    int         stb_cycles  = 0;
    int         acks        = 0;
    int         tx          = 0;
    int         err_tx      = -1;
    int         rty_tx      = -1;
    int         last_ack_cyc = 0;
    bit         silent      = 1'b0;
    logic [7:0] next_byte   = 8'h00;
    logic [7:0] dat_step    = 8'h01;
    int         issue_q[$];

    wb_trng_fetch #(
        .TRNG_ADDR (32'hA000_0010),
        .DEPTH     (4),
        .TIMEOUT   (8)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cti_o  (wb_cti_o),
        .wb_bte_o  (wb_bte_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_rty_i  (wb_rty_i),
        .enable    (enable),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .level     (level),
        .fault     (fault),
        .fault_clr (fault_clr)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then play the responder: it terminates
    // each strobe in the cycle after the strobe first appears.
    task automatic tick();
        @(negedge wb_clk);
        cycle++;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (wb_stb_o) begin
            stb_cycles++;
            if (stb_age == 0) begin
                stb_issued++;
                issue_q.push_back(cycle);
            end
            stb_age++;
            if (stb_age == 2 && !silent) begin
                if (tx == err_tx) begin
                    wb_err_i = 1'b1;
                end else if (tx == rty_tx) begin
                    wb_rty_i = 1'b1;
                end else begin
                    wb_ack_i     = 1'b1;
                    wb_dat_i     = next_byte;
                    next_byte    = next_byte + dat_step;
                    acks++;
                    last_ack_cyc = cycle;
                end
                tx++;
            end
        end else begin
            stb_age = 0;
        end
    endtask

    initial begin
        int a0;
        int n0;
        int valid_cyc;
        logic [31:0] drain_exp [3];

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_valid", {31'd0, rnd_valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_data", rnd_data, 32'd0);
        chk("const_sideband", {24'd0, wb_dat_o, wb_we_o, wb_cti_o, wb_bte_o}, 32'd0);
        wb_rst = 1'b0;
        tick(); tick();
        chk("disabled_no_stb", stb_issued, 0);

        // ---------------- one word, ack after one cycle ----------------
        next_byte = 8'h11;
        dat_step  = 8'h11;
        issue_q.delete();
        enable = 1'b1;
        for (int i = 0; i < 40 && !rnd_valid; i++) begin
            tick();
            if (wb_stb_o) chk("req_addr", wb_adr_o, 32'hA000_0010);
        end
        valid_cyc = cycle;
        chk("w1_valid", {31'd0, rnd_valid}, 32'd1);
        chk("w1_data", rnd_data, 32'h4433_2211);
        chk("w1_valid_after_4th_ack", valid_cyc, last_ack_cyc + 1);
        tick();
        // second word's first strobe lands one 12-cycle word period later
        chk("word_period", (issue_q.size() >= 5) ? (issue_q[4] - issue_q[0]) : -1, 12);

        // ---------------- fill FIFO, rnd_ready low ----------------
        for (int i = 0; i < 60; i++) tick();
        chk("fill_acks", acks, 16);
        chk("fill_stbs", stb_issued, 16);
        chk("fill_level", {29'd0, level}, 32'd4);
        chk("fill_no_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("fill_head", rnd_data, 32'h4433_2211);

        // pop one word: a new strobe must follow within 2 cycles
        n0 = stb_issued;
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        chk("pop_level", {29'd0, level}, 32'd3);
        chk("pop_head", rnd_data, 32'h8877_6655);
        for (int i = 0; i < 2 && stb_issued == n0; i++) tick();
        chk("pop_restart_stb", stb_issued, n0 + 1);

        // drop enable mid-transaction: it completes, partial byte is kept
        enable = 1'b0;
        a0 = acks;
        for (int i = 0; i < 6; i++) tick();
        chk("en_off_one_ack", acks, a0 + 1);
        chk("en_off_no_more_stb", stb_issued, n0 + 1);

        drain_exp[0] = 32'h8877_6655;
        drain_exp[1] = 32'hCCBB_AA99;
        drain_exp[2] = 32'h10FF_EEDD;
        rnd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("drain_order", rnd_data, drain_exp[k]);
            tick();
        end
        rnd_ready = 1'b0;
        chk("drain_level", {29'd0, level}, 32'd0);
        chk("drain_empty", {31'd0, rnd_valid}, 32'd0);
        chk("drain_empty_data", rnd_data, 32'd0);

        // resume: byte 0x21 already sits in slot 0
        enable = 1'b1;
        for (int i = 0; i < 30 && !rnd_valid; i++) tick();
        chk("resume_word", rnd_data, 32'h5443_3221);
        enable = 1'b0;
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        chk("resume_popped", {29'd0, level}, 32'd0);

        // ---------------- err on the 3rd byte ----------------
        next_byte = 8'hA1;
        dat_step  = 8'h01;
        err_tx    = tx + 2;
        enable    = 1'b1;
        for (int i = 0; i < 20 && !fault; i++) tick();
        chk("err_fault", {31'd0, fault}, 32'd1);
        n0 = stb_issued;
        for (int i = 0; i < 5; i++) tick();
        chk("err_no_stb", stb_issued, n0);
        chk("err_level", {29'd0, level}, 32'd0);
        err_tx = -1;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("err_cleared", {31'd0, fault}, 32'd0);
        for (int i = 0; i < 30 && !rnd_valid; i++) tick();
        chk("err_fresh_word", rnd_data, 32'hA6A5_A4A3);
        enable = 1'b0;
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;

        // ---------------- rty on byte 1 ----------------
        next_byte = 8'hAA;
        rty_tx    = tx + 1;
        enable    = 1'b1;
        for (int i = 0; i < 30 && !rnd_valid; i++) tick();
        chk("rty_word", rnd_data, 32'hADAC_ABAA);
        chk("rty_no_fault", {31'd0, fault}, 32'd0);
        enable = 1'b0;
        rty_tx = -1;
        tick();
        chk("rty_level", {29'd0, level}, 32'd1);

        // ---------------- timeout ----------------
        silent     = 1'b1;
        stb_cycles = 0;
        enable     = 1'b1;
        for (int i = 0; i < 30 && !fault; i++) tick();
        chk("tmo_stb_cycles", stb_cycles, 8);
        chk("tmo_fault", {31'd0, fault}, 32'd1);
        chk("tmo_stb_low", {31'd0, wb_stb_o}, 32'd0);
        enable = 1'b0;
        silent = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("tmo_cleared", {31'd0, fault}, 32'd0);

        // ---------------- async reset mid-transfer ----------------
        next_byte = 8'h01;
        a0 = acks;
        enable = 1'b1;
        for (int i = 0; i < 20 && !((acks - a0) == 2 && wb_stb_o); i++) tick();
        chk("rst_mid_setup", {31'd0, ((acks - a0) == 2) && wb_stb_o}, 32'd1);
        #1 wb_rst = 1'b1;
        #1;
        chk("arst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("arst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("arst_level", {29'd0, level}, 32'd0);
        chk("arst_valid", {31'd0, rnd_valid}, 32'd0);
        chk("arst_data", rnd_data, 32'd0);
        tick();
        wb_rst    = 1'b0;
        next_byte = 8'h61;
        for (int i = 0; i < 30 && !rnd_valid; i++) tick();
        chk("arst_slot0_word", rnd_data, 32'h6463_6261);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_wb_trng_fetch
`default_nettype wire
